// File: rtl/weight_loader_if.sv
// Stream and row-write bus between the weight source, weight_loader and the
// weight_reg array.
interface weight_loader_if #(
    parameter int WEIGHT_BW = 8,
    parameter int ROWS      = 64,
    parameter int COLS      = 64
) ();
    logic                          start;
    logic                          s_valid;
    logic signed [WEIGHT_BW-1:0]   s_data;
    logic                          s_ready;
    logic [COLS*WEIGHT_BW-1:0]     W;
    logic [ROWS-1:0]               we_rl;
    logic                          busy;
    logic                          done;

    modport master (
        output start, s_valid, s_data,
        input  s_ready, W, we_rl, busy, done
    );

    modport slave (
        input  start, s_valid, s_data,
        output s_ready, W, we_rl, busy, done
    );
endinterface

// File: rtl/weight_loader.sv
// Packs a serial signed weight stream into COLS-wide row words and strobes
// each of the ROWS weight_reg rows once per start command.
module weight_loader #(
    parameter int WEIGHT_BW = 8,
    parameter int ROWS      = 64,
    parameter int COLS      = 64
) (
    input  logic          clk,
    input  logic          rstn,
    weight_loader_if.slave bus
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                     state;
    logic [CW-1:0]              col;
    logic [RW-1:0]              row;
    logic [COLS*WEIGHT_BW-1:0]  buffer;
    logic [COLS*WEIGHT_BW-1:0]  row_word;
    logic [COLS*WEIGHT_BW-1:0]  w_q;
    logic [ROWS-1:0]            we_rl_q;
    logic                       s_ready_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       accept;
    int unsigned                col_base;

    // Buffer with the beat currently on the stream merged into its column slot;
    // this is the full row word when the last beat of a row is accepted.
    always_comb begin
        col_base = 32'(col) * WEIGHT_BW;
        row_word = buffer;
        row_word[col_base +: WEIGHT_BW] = bus.s_data;
    end

    assign accept = bus.s_valid && s_ready_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            buffer    <= '0;
            w_q       <= '0;
            we_rl_q   <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= FILL;
                        row       <= '0;
                        col       <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        buffer <= row_word;
                        if (col == COL_LAST) begin
                            col       <= '0;
                            state     <= WRITE;
                            s_ready_q <= 1'b0;
                            w_q       <= row_word;
                            we_rl_q   <= ROWS'(1) << row;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                WRITE: begin
                    we_rl_q <= '0;
                    if (row == ROW_LAST) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        row       <= row + RW'(1);
                        state     <= FILL;
                        s_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.W       = w_q;
    assign bus.we_rl   = we_rl_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // Structural invariants of the registered outputs.
    we_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(we_rl_q));
    we_in_write: assert property (@(posedge clk) disable iff (!rstn)
        (we_rl_q != '0) == (state == WRITE));
    done_in_done: assert property (@(posedge clk) disable iff (!rstn)
        done_q == (state == DONE));
    busy_not_idle: assert property (@(posedge clk) disable iff (!rstn)
        busy_q == (state != IDLE));
endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader: beat-count reference model plus literal
// checks on a 4x4 instance and a default-size smoke load.
module tb_weight_loader;
    localparam int BW = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int BR = 64;
    localparam int BC = 64;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    weight_loader_if #(.WEIGHT_BW(BW), .ROWS(R), .COLS(C)) bus ();
    weight_loader #(.WEIGHT_BW(BW), .ROWS(R), .COLS(C)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    weight_loader_if big ();
    weight_loader u_big (.clk(clk), .rstn(rstn), .bus(big));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a load is a count of accepted beats; every COLS beats
    // produce one write cycle, and the final write is followed by one done cycle.
    bit               m_loading, m_wr, m_done;
    int               m_nbeats, m_wr_row;
    logic [C*BW-1:0]  m_word;
    logic [BW-1:0]    mem [R*C];

    function automatic logic [C*BW-1:0] pack(input int r);
        logic [C*BW-1:0] w;
        for (int c = 0; c < C; c++) w[c*BW +: BW] = mem[r*C + c];
        return w;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_loading = 0; m_wr = 0; m_done = 0;
            m_nbeats = 0; m_wr_row = 0; m_word = '0;
        end else if (m_done) begin
            m_done = 0;
            m_loading = 0;
        end else if (m_wr) begin
            m_wr = 0;
            if (m_nbeats == R*C) m_done = 1;
        end else if (m_loading) begin
            if (bus.s_valid) begin
                mem[m_nbeats] = bus.s_data;
                m_nbeats++;
                if (m_nbeats % C == 0) begin
                    m_wr = 1;
                    m_wr_row = m_nbeats / C - 1;
                    m_word = pack(m_wr_row);
                end
            end
        end else if (bus.start) begin
            m_loading = 1;
            m_nbeats = 0;
        end
    end

    always @(negedge clk) begin
        logic [R-1:0] ewe;
        if (rstn) begin
            ewe = m_wr ? (R'(1) << m_wr_row) : '0;
            check("busy", bus.busy, m_loading);
            check("s_ready", bus.s_ready, m_loading && !m_wr && !m_done);
            check("we_rl", bus.we_rl, ewe);
            check("W", bus.W, m_word);
            check("done", bus.done, m_done);
        end
    end

    // Log of what the DUT actually wrote, for the literal expectations.
    int              wr_cyc [R];
    logic [C*BW-1:0] wr_word [R];
    int              done_cnt, done_cyc, start_cyc;
    always @(negedge clk) begin
        if (rstn) begin
            for (int r = 0; r < R; r++)
                if (bus.we_rl[r]) begin
                    wr_cyc[r] = cyc;
                    wr_word[r] = bus.W;
                end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_logs();
        for (int r = 0; r < R; r++) begin
            wr_cyc[r] = -1;
            wr_word[r] = '0;
        end
        done_cnt = 0;
        done_cyc = -1;
    endtask

    logic [BW-1:0] src [R*C];

    task automatic run_load(input int stall_at, input int stall_len, input bit rnd,
                            input int stray_at, input bit stray_done, input int abort_at);
        int idx = 0;
        int stalled = 0;
        bit seen_done = 0;
        bit finished = 0;
        bit v;
        clear_logs();
        @(negedge clk); #1;
        bus.start = 1'b1;
        bus.s_valid = 1'b0;
        start_cyc = cyc;
        for (int t = 0; t < 400 && !finished; t++) begin
            @(negedge clk); #1;
            if (abort_at >= 0 && idx == abort_at) begin
                rstn = 1'b0;
                #1;
                check("rst_W", bus.W, 0);
                check("rst_we_rl", bus.we_rl, 0);
                check("rst_s_ready", bus.s_ready, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                bus.start = 1'b0;
                bus.s_valid = 1'b0;
                @(negedge clk);
                @(negedge clk); #1;
                rstn = 1'b1;
                return;
            end
            if (seen_done) begin
                bus.start = 1'b0;
                bus.s_valid = 1'b0;
                finished = 1;
            end else begin
                bus.start = (t == stray_at) || (stray_done && bus.done);
                if (bus.done) seen_done = 1;
                v = (idx < R*C);
                if (v && idx == stall_at && stalled < stall_len) begin
                    v = 0;
                    if (bus.s_ready) stalled++;
                end else if (v && rnd && $urandom_range(0, 3) == 0) begin
                    v = 0;
                end
                bus.s_valid = v;
                bus.s_data = v ? src[idx] : BW'($urandom);
                if (v && bus.s_ready) idx++;
            end
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL load_timeout: got no done after %0d beats, required done", idx);
        end
    endtask

    // Default-size smoke load.
    logic [7:0] bsrc [BR*BC];
    bit         big_chk = 0;
    int         brow = 0;
    always @(negedge clk) begin
        logic [BC*8-1:0] expw;
        if (rstn && big_chk && big.we_rl != '0) begin
            for (int c = 0; c < BC; c++) expw[c*8 +: 8] = bsrc[brow*BC + c];
            check("big_we_rl", big.we_rl, 64'(1) << brow);
            vectors++;
            if (big.W !== expw) begin
                miscompares++;
                $display("FAIL big_W row %0d: got %h expected %h", brow, big.W, expw);
            end
            brow++;
        end
    end

    task automatic run_big();
        int idx = 0;
        int bs;
        int bdone = -1;
        for (int i = 0; i < BR*BC; i++) bsrc[i] = 8'($urandom);
        big_chk = 1;
        brow = 0;
        @(negedge clk); #1;
        big.start = 1'b1;
        bs = cyc;
        for (int t = 0; t < 6000 && bdone < 0; t++) begin
            @(negedge clk); #1;
            big.start = 1'b0;
            if (big.done) bdone = cyc;
            big.s_valid = (idx < BR*BC);
            big.s_data = (idx < BR*BC) ? bsrc[idx] : 8'h00;
            if (big.s_valid && big.s_ready) idx++;
        end
        big.s_valid = 1'b0;
        check("big_done_latency", bdone - bs, BR*(BC+1)+1);
        check("big_rows_written", brow, BR);
        big_chk = 0;
    endtask

    initial begin
        bus.start = 0; bus.s_valid = 0; bus.s_data = '0;
        big.start = 0; big.s_valid = 0; big.s_data = '0;
        clear_logs();

        // Reset with random inputs
        rstn = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            bus.start = 1'($urandom);
            bus.s_valid = 1'($urandom);
            bus.s_data = BW'($urandom);
            #1;
            check("reset_W", bus.W, 0);
            check("reset_we_rl", bus.we_rl, 0);
            check("reset_s_ready", bus.s_ready, 0);
            check("reset_busy", bus.busy, 0);
            check("reset_done", bus.done, 0);
        end
        @(negedge clk); #1;
        bus.start = 0; bus.s_valid = 0;
        rstn = 1'b1;

        // Full back-to-back load of 01..10
        for (int i = 0; i < R*C; i++) src[i] = 8'(i + 1);
        run_load(-1, 0, 0, -1, 0, -1);
        check("full_row0_W", wr_word[0], 32'h04030201);
        check("full_row0_cycle", wr_cyc[0] - start_cyc, 5);
        check("full_row3_W", wr_word[3], 32'h100F0E0D);
        check("full_done_cycle", done_cyc - start_cyc, 21);
        check("full_done_count", done_cnt, 1);
        check("full_busy_after", bus.busy, 0);

        // Back-pressure: 3 idle cycles after 2 beats of row 1
        run_load(C + 2, 3, 0, -1, 0, -1);
        check("bp_row0_cycle", wr_cyc[0] - start_cyc, 5);
        check("bp_row1_cycle", wr_cyc[1] - start_cyc, 13);
        check("bp_row1_W", wr_word[1], 32'h08070605);
        check("bp_done_cycle", done_cyc - start_cyc, 24);

        // Signed extremes stored verbatim
        src[0] = 8'h80; src[1] = 8'hFF; src[2] = 8'h7F; src[3] = 8'h00;
        for (int i = C; i < R*C; i++) src[i] = 8'($urandom);
        run_load(-1, 0, 0, -1, 0, -1);
        check("signed_row0_W", wr_word[0], 32'h007FFF80);

        // Stray starts mid-load and on the done cycle
        for (int i = 0; i < R*C; i++) src[i] = 8'($urandom);
        run_load(-1, 0, 1, 7, 1, -1);
        repeat (3) @(negedge clk);
        #1;
        check("stray_done_count", done_cnt, 1);
        check("stray_busy_after", bus.busy, 0);

        // Reset while filling row 2, then a clean reload
        run_load(-1, 0, 0, -1, 0, 2*C + 1);
        check("abort_rows_written", (wr_cyc[0] >= 0) && (wr_cyc[1] >= 0) && (wr_cyc[2] < 0), 1);
        for (int i = 0; i < R*C; i++) src[i] = 8'($urandom);
        run_load(-1, 0, 0, -1, 0, -1);
        check("reload_row0_cycle", wr_cyc[0] - start_cyc, 5);
        check("reload_row0_W", wr_word[0], {src[3], src[2], src[1], src[0]});
        check("reload_done_count", done_cnt, 1);

        // Randomized loads with gapped valid
        repeat (3) begin
            for (int i = 0; i < R*C; i++) src[i] = 8'($urandom);
            run_load(-1, 0, 1, -1, 0, -1);
            check("rand_done_count", done_cnt, 1);
            check("rand_row3_W", wr_word[3], {src[15], src[14], src[13], src[12]});
        end

        run_big();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
